dsp_post_accum: RTL and testbench

Multiply / post-add / accumulate stage that consumes the registered 18-bit A and B operands produced by the upstream pipeline-register stages. It forms a signed 18x18 product with an optional M register, and adds, subtracts or accumulates it against C or P with an optional P register. It drives the final P, CARRYOUT and a sticky overflow flag to the slice outputs. A valid bit travels with each sample so downstream logic sees which P values are real.

---
 rtl/dsp_post_accum.sv | 178 +++++++++++++++++
 tb/tb_dsp_post_accum.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_post_accum.sv
// Signed 18x18 multiply with optional M register, followed by an add/sub/accumulate post-adder
// with optional P register. Define DSP_POST_SAT_EN to saturate P on signed overflow.
module dsp_post_accum #(
  parameter int unsigned MREG = 1,
  parameter int unsigned PREG = 1
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        CEM,
  input  logic        CEP,
  input  logic        in_valid,
  input  logic [17:0] A_in,
  input  logic [17:0] B_in,
  input  logic [47:0] C_in,
  input  logic [5:0]  opmode,
  input  logic        clr_ovf,
  output logic [35:0] M,
  output logic [47:0] P,
  output logic        CARRYOUT,
  output logic        out_valid,
  output logic        ovf_sticky
);

  logic signed [35:0] m_raw;
  logic [35:0]        m_s;
  logic [5:0]         opm_s;
  logic [47:0]        c_s;
  logic               vld_s;

  assign m_raw = $signed(A_in) * $signed(B_in);

  // opmode, C and valid ride along with the product so each field matches its sample.
  if (MREG != 0) begin : g_mreg
    logic [35:0] m_q, m_d;
    logic [5:0]  opm_q, opm_d;
    logic [47:0] c_q, c_d;
    logic        vld_q, vld_d;

    always_comb begin
      m_d   = m_q;
      opm_d = opm_q;
      c_d   = c_q;
      vld_d = vld_q;
      if (CEM) begin
        m_d   = m_raw;
        opm_d = opmode;
        c_d   = C_in;
        vld_d = in_valid;
      end
    end

    always_ff @(posedge clk) begin
      if (RST) begin
        m_q   <= '0;
        opm_q <= '0;
        c_q   <= '0;
        vld_q <= 1'b0;
      end else begin
        m_q   <= m_d;
        opm_q <= opm_d;
        c_q   <= c_d;
        vld_q <= vld_d;
      end
    end

    assign m_s   = m_q;
    assign opm_s = opm_q;
    assign c_s   = c_q;
    assign vld_s = vld_q;
  end else begin : g_mcomb
    logic unused_cem;
    assign unused_cem = CEM;
    assign m_s        = m_raw;
    assign opm_s      = opmode;
    assign c_s        = C_in;
    assign vld_s      = in_valid;
  end

  assign M = m_s;

  logic [47:0] p_fb;
  logic [47:0] x, z;
  logic [48:0] xc49, r49;
  logic [49:0] xc50, e50;
  logic        ovf;
  logic [47:0] p_res;
  logic        co_res;

  always_comb begin
    case (opm_s[1:0])
      2'b01:   x = {{12{m_s[35]}}, m_s};
      2'b10:   x = p_fb;
      default: x = '0;
    endcase
    case (opm_s[3:2])
      2'b01:   z = p_fb;
      2'b10:   z = c_s;
      default: z = '0;
    endcase

    xc49 = {1'b0, x} + {48'd0, opm_s[5]};
    if (opm_s[4]) r49 = {1'b0, z} - xc49;
    else          r49 = {1'b0, z} + xc49;

    // Signed view of the same operation; in range iff the top three bits agree.
    xc50 = {{2{x[47]}}, x} + {49'd0, opm_s[5]};
    if (opm_s[4]) e50 = {{2{z[47]}}, z} - xc50;
    else          e50 = {{2{z[47]}}, z} + xc50;
    ovf = (e50[49:47] != 3'b000) && (e50[49:47] != 3'b111);

    p_res  = r49[47:0];
    co_res = r49[48];
`ifdef DSP_POST_SAT_EN
    if (ovf) begin
      p_res  = e50[49] ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
      co_res = 1'b0;
    end
`endif
  end

  if (PREG != 0) begin : g_preg
    logic [47:0] p_q, p_d;
    logic        co_q, co_d;
    logic        ov_q, ov_d;

    always_comb begin
      p_d  = p_q;
      co_d = co_q;
      ov_d = ov_q;
      if (CEP) begin
        p_d  = p_res;
        co_d = co_res;
        ov_d = vld_s;
      end
    end

    always_ff @(posedge clk) begin
      if (RST) begin
        p_q  <= '0;
        co_q <= 1'b0;
        ov_q <= 1'b0;
      end else begin
        p_q  <= p_d;
        co_q <= co_d;
        ov_q <= ov_d;
      end
    end

    assign p_fb      = p_q;
    assign P         = p_q;
    assign CARRYOUT  = co_q;
    assign out_valid = ov_q;
  end else begin : g_pcomb
    // No P register means no feedback source; P selects read as zero.
    assign p_fb      = '0;
    assign P         = p_res;
    assign CARRYOUT  = co_res;
    assign out_valid = vld_s;
  end

  logic ovf_sticky_q, ovf_sticky_d;

  always_comb begin
    ovf_sticky_d = ovf_sticky_q;
    if (CEP) begin
      if (clr_ovf)      ovf_sticky_d = 1'b0;
      if (ovf && vld_s) ovf_sticky_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (RST) ovf_sticky_q <= 1'b0;
    else     ovf_sticky_q <= ovf_sticky_d;
  end

  assign ovf_sticky = ovf_sticky_q;

endmodule

// File: tb/tb_dsp_post_accum.sv
// Bench for dsp_post_accum: directed checks plus a randomized scoreboard run against an
// arithmetic reference model. Honours DSP_POST_SAT_EN for expected saturation.
module tb_dsp_post_accum;

  logic        clk = 1'b0;
  logic        rst, cem, cep, in_valid, clr_ovf;
  logic [17:0] a, b;
  logic [47:0] c;
  logic [5:0]  op;
  logic [35:0] m, m0;
  logic [47:0] p, p0;
  logic        co, co0, ov, ov0, st, st0;

  always #5 clk = ~clk;

  dsp_post_accum dut (
    .clk(clk), .RST(rst), .CEM(cem), .CEP(cep), .in_valid(in_valid),
    .A_in(a), .B_in(b), .C_in(c), .opmode(op), .clr_ovf(clr_ovf),
    .M(m), .P(p), .CARRYOUT(co), .out_valid(ov), .ovf_sticky(st)
  );

  dsp_post_accum #(.MREG(0), .PREG(0)) dut_byp (
    .clk(clk), .RST(rst), .CEM(cem), .CEP(cep), .in_valid(in_valid),
    .A_in(a), .B_in(b), .C_in(c), .opmode(op), .clr_ovf(clr_ovf),
    .M(m0), .P(p0), .CARRYOUT(co0), .out_valid(ov0), .ovf_sticky(st0)
  );

  typedef struct {
    logic [47:0] p;
    logic        co;
    logic        st;
  } exp_t;

  typedef struct {
    logic [17:0] a;
    logic [17:0] b;
    logic [47:0] c;
    logic [5:0]  op;
    logic        v;
  } smp_t;

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  logic mon_en = 1'b0;
  logic upd_q = 1'b0;

  logic [47:0] p_m;
  logic        st_m;
  smp_t        prv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    op = '0;
  endtask

  task automatic drive(input smp_t s);
    a = s.a;
    b = s.b;
    c = s.c;
    op = s.op;
    in_valid = s.v;
  endtask

  task automatic run_one(input logic [17:0] ra, input logic [17:0] rb, input logic [47:0] rc,
                         input logic [5:0] rop);
    a = ra;
    b = rb;
    c = rc;
    op = rop;
    in_valid = 1'b1;
    step();
    idle();
    step();
  endtask

  // Reference model: one sample's effect on P, applied in sample order.
  function automatic void model_step(input smp_t s, input logic clr);
    longint      prod, xv, zv, e, cin;
    logic [47:0] xu, zu, pr;
    logic [63:0] ru;
    logic        cr, ovf;
    prod = longint'($signed(s.a)) * longint'($signed(s.b));
    cin  = s.op[5] ? 1 : 0;
    xv = 0;
    if (s.op[1:0] == 2'd1)      xv = prod;
    else if (s.op[1:0] == 2'd2) xv = longint'($signed(p_m));
    zv = 0;
    if (s.op[3:2] == 2'd1)      zv = longint'($signed(p_m));
    else if (s.op[3:2] == 2'd2) zv = longint'($signed(s.c));
    e  = s.op[4] ? zv - (xv + cin) : zv + xv + cin;
    xu = xv[47:0];
    zu = zv[47:0];
    ru = s.op[4] ? {16'd0, zu} - ({16'd0, xu} + {63'd0, s.op[5]})
                 : {16'd0, zu} + {16'd0, xu} + {63'd0, s.op[5]};
    pr  = ru[47:0];
    cr  = ru[48];
    ovf = (e > 64'sd140737488355327) || (e < -64'sd140737488355328);
`ifdef DSP_POST_SAT_EN
    if (ovf) begin
      pr = (e < 0) ? 48'h8000_0000_0000 : 48'h7FFF_FFFF_FFFF;
      cr = 1'b0;
    end
`endif
    st_m = (st_m & ~clr) | (ovf & s.v);
    p_m  = pr;
    if (s.v) sb.push_back('{p: pr, co: cr, st: st_m});
  endfunction

  function automatic smp_t rand_sample();
    smp_t        s;
    logic [63:0] t;
    s.a = 18'($urandom);
    if ($urandom_range(0, 4) == 0) s.a = $urandom_range(0, 1) ? 18'h20000 : 18'h1FFFF;
    s.b = 18'($urandom);
    if ($urandom_range(0, 4) == 0) s.b = $urandom_range(0, 1) ? 18'h20000 : 18'h1FFFF;
    t = {$urandom, $urandom};
    s.c = t[47:0];
    if ($urandom_range(0, 5) == 0) s.c = 48'h7FFF_FFFF_FFF0 + 48'($urandom_range(0, 15));
    if ($urandom_range(0, 5) == 0) s.c = 48'h8000_0000_0000 + 48'($urandom_range(0, 15));
    case ($urandom_range(0, 5))
      0:       s.op = 6'($urandom_range(0, 63));
      1:       s.op = 6'b000101;
      2:       s.op = 6'b001001;
      3:       s.op = 6'b011001;
      4:       s.op = 6'b000110;
      default: s.op = 6'b010101;
    endcase
    s.v = ($urandom_range(0, 3) != 0);
    return s;
  endfunction

  always @(posedge clk) upd_q <= cep && !rst && mon_en;

  always @(negedge clk) begin
    exp_t e;
    if (upd_q && ov) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_underflow: got out_valid=1 expected no pending sample");
      end else begin
        e = sb.pop_front();
        chk("sb_p", 64'(p), 64'(e.p));
        chk("sb_co", 64'(co), 64'(e.co));
        chk("sb_sticky", 64'(st), 64'(e.st));
      end
    end
  end

  initial begin
    logic [47:0] ovf_pos_p, ovf_neg_p;
    smp_t        s;
    logic        clr;
`ifdef DSP_POST_SAT_EN
    ovf_pos_p = 48'h7FFF_FFFF_FFFF;
    ovf_neg_p = 48'h8000_0000_0000;
`else
    ovf_pos_p = 48'h8000_0000_0000;
    ovf_neg_p = 48'h7FFF_FFFF_FFFF;
`endif
    rst = 1'b1;
    cem = 1'b1;
    cep = 1'b1;
    clr_ovf = 1'b0;
    idle();
    step();
    step();
    rst = 1'b0;

    // Product path, plus the combinational bypass instance on the same inputs.
    a = -18'sd3;
    b = 18'd5;
    op = 6'b100001;
    in_valid = 1'b1;
    #1;
    chk("byp_m", 64'(m0), 64'(36'hF_FFFF_FFF1));
    chk("byp_p", 64'(p0), 64'(48'hFFFF_FFFF_FFF2));
    chk("byp_valid", 64'(ov0), 64'd1);
    step();
    chk("prod_m", 64'(m), 64'(36'hF_FFFF_FFF1));
    idle();
    step();
    chk("prod_p", 64'(p), 64'(48'hFFFF_FFFF_FFF2));
    chk("prod_valid", 64'(ov), 64'd1);
    step();
    chk("prod_valid_drop", 64'(ov), 64'd0);

    // Accumulate four samples, stall one cycle, then one more step with a zero product.
    rst = 1'b1;
    step();
    rst = 1'b0;
    a = 18'd100;
    b = 18'd200;
    op = 6'b000101;
    in_valid = 1'b1;
    #1;
    chk("byp_acc0", 64'(p0), 64'd20000);
    step();
    chk("byp_acc1", 64'(p0), 64'd20000);
    step();
    chk("acc_1", 64'(p), 64'd20000);
    step();
    chk("acc_2", 64'(p), 64'd40000);
    step();
    chk("acc_3", 64'(p), 64'd60000);
    cem = 1'b0;
    cep = 1'b0;
    step();
    chk("acc_hold", 64'(p), 64'd60000);
    chk("acc_hold_valid", 64'(ov), 64'd1);
    cem = 1'b1;
    cep = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    step();
    chk("acc_4", 64'(p), 64'd80000);
    chk("acc_4_valid", 64'(ov), 64'd1);
    step();
    chk("acc_invalid", 64'(ov), 64'd0);

    // Subtract and borrow.
    run_one(18'd3, 18'd1, 48'd10, 6'b011001);
    chk("sub_p", 64'(p), 64'd7);
    chk("sub_co", 64'(co), 64'd0);
    run_one(18'd1, 18'd1, 48'd0, 6'b011001);
    chk("borrow_p", 64'(p), 64'(48'hFFFF_FFFF_FFFF));
    chk("borrow_co", 64'(co), 64'd1);

    // Overflow, clear alone, clear colliding with a new overflow.
    run_one(18'd1, 18'd1, 48'h7FFF_FFFF_FFFF, 6'b001001);
    chk("ovf_sticky", 64'(st), 64'd1);
    chk("ovf_p", 64'(p), 64'(ovf_pos_p));
    chk("ovf_co", 64'(co), 64'd0);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_alone", 64'(st), 64'd0);
    run_one(18'd1, 18'd1, 48'h8000_0000_0000, 6'b011001);
    chk("neg_ovf_p", 64'(p), 64'(ovf_neg_p));
    chk("neg_ovf_sticky", 64'(st), 64'd1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    a = 18'd1;
    b = 18'd1;
    c = 48'h7FFF_FFFF_FFFF;
    op = 6'b001001;
    in_valid = 1'b1;
    step();
    idle();
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("set_beats_clr", 64'(st), 64'd1);
    step();
    chk("sticky_held", 64'(st), 64'd1);

    // Reset overrides disabled enables and a pending clear, with busy inputs.
    a = 18'd5;
    b = 18'd7;
    c = 48'd123;
    op = 6'b000101;
    in_valid = 1'b1;
    step();
    step();
    rst = 1'b1;
    cem = 1'b0;
    cep = 1'b0;
    step();
    chk("rst_m", 64'(m), 64'd0);
    chk("rst_p", 64'(p), 64'd0);
    chk("rst_co", 64'(co), 64'd0);
    chk("rst_valid", 64'(ov), 64'd0);
    chk("rst_sticky", 64'(st), 64'd0);
    rst = 1'b0;
    cem = 1'b1;
    cep = 1'b1;
    run_one(18'd2, 18'd3, 48'd0, 6'b000101);
    chk("post_rst_fb", 64'(p), 64'd6);

    // Randomized run through the scoreboard.
    rst = 1'b1;
    idle();
    step();
    rst = 1'b0;
    p_m = '0;
    st_m = 1'b0;
    prv = '{a: '0, b: '0, c: '0, op: '0, v: 1'b0};
    mon_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s = rand_sample();
      if ($urandom_range(0, 9) == 0) begin
        cem = 1'b0;
        cep = 1'b0;
        clr_ovf = 1'b0;
        drive(s);
      end else begin
        cem = 1'b1;
        cep = 1'b1;
        clr = ($urandom_range(0, 19) == 0);
        clr_ovf = clr;
        drive(s);
        model_step(prv, clr);
        prv = s;
      end
      step();
    end
    cem = 1'b1;
    cep = 1'b1;
    clr_ovf = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s = '{a: '0, b: '0, c: '0, op: '0, v: 1'b0};
      drive(s);
      model_step(prv, 1'b0);
      prv = s;
      step();
    end
    step();
    step();
    mon_en = 1'b0;
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
